// File: rtl/mem_arbiter_if.sv
// Bundle of the prefetcher, scheduler and memory-interface signals handled by mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if #(
  parameter int unsigned IO_BITS  = 2,
  parameter int unsigned CMD_BITS = 2,
  parameter int unsigned DEPTH    = 7
);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic                pf_cmd_valid;
  logic [CMD_BITS-1:0] pf_cmd;
  logic [IO_BITS-1:0]  pf_data;
  logic                sc_cmd_valid;
  logic [CMD_BITS-1:0] sc_cmd;
  logic [IO_BITS-1:0]  sc_data;
  logic                sc_hold;
  logic                sc_reply_wanted;
  logic                jump;
  logic                tx_active;
  logic [2:0]          tx_ev;
  logic [3:0]          rx_ev;

  logic                tx_command_valid;
  logic [CMD_BITS-1:0] tx_command;
  logic [IO_BITS-1:0]  tx_data;
  logic                sc_owns_tx;
  logic [2:0]          pf_tx_ev;
  logic [2:0]          sc_tx_ev;
  logic [3:0]          pf_rx_ev;
  logic [3:0]          sc_rx_ev;
  logic [OW-1:0]       outstanding;
  logic                full;

  modport slave (
    input  pf_cmd_valid, pf_cmd, pf_data,
    input  sc_cmd_valid, sc_cmd, sc_data, sc_hold, sc_reply_wanted, jump,
    input  tx_active, tx_ev, rx_ev,
    output tx_command_valid, tx_command, tx_data, sc_owns_tx,
    output pf_tx_ev, sc_tx_ev, pf_rx_ev, sc_rx_ev, outstanding, full
  );

  modport master (
    output pf_cmd_valid, pf_cmd, pf_data,
    output sc_cmd_valid, sc_cmd, sc_data, sc_hold, sc_reply_wanted, jump,
    output tx_active, tx_ev, rx_ev,
    input  tx_command_valid, tx_command, tx_data, sc_owns_tx,
    input  pf_tx_ev, sc_tx_ev, pf_rx_ev, sc_rx_ev, outstanding, full
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the memory TX channel between prefetcher and scheduler and routes RX
// replies back to whoever issued each read, using a circular queue of owner tags.
module mem_arbiter #(
  parameter int unsigned IO_BITS  = 2,
  parameter int unsigned CMD_BITS = 2,
  parameter int unsigned DEPTH    = 7,
  parameter int unsigned READ_CMD = 0
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic             own_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] tags_q;

  logic sc_want, sc_owns, full, empty, enq, deq, tag, head;

  assign sc_want = bus.sc_cmd_valid | bus.sc_hold;
  assign sc_owns = bus.tx_active ? own_q : sc_want;
  assign full    = (cnt_q == OW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign tag     = sc_owns & ~bus.jump;
  assign head    = tags_q[rd_ptr_q];

  assign enq = bus.tx_ev[0] & (bus.tx_command == CMD_BITS'(READ_CMD))
             & (sc_owns ? bus.sc_reply_wanted : 1'b1) & ~full;
  assign deq = bus.rx_ev[3] & ~empty;

  always_comb begin
    bus.sc_owns_tx       = sc_owns;
    bus.tx_command       = sc_owns ? bus.sc_cmd  : bus.pf_cmd;
    bus.tx_data          = sc_owns ? bus.sc_data : bus.pf_data;
    bus.tx_command_valid = (sc_owns ? bus.sc_cmd_valid : bus.pf_cmd_valid) & ~full;
    bus.sc_tx_ev         = sc_owns ? bus.tx_ev : '0;
    bus.pf_tx_ev         = sc_owns ? '0 : bus.tx_ev;
    // Head is still valid during the done cycle, so the done pulse itself is routed.
    bus.sc_rx_ev         = (~empty &  head) ? bus.rx_ev : '0;
    bus.pf_rx_ev         = (~empty & ~head) ? bus.rx_ev : '0;
    bus.outstanding      = cnt_q;
    bus.full             = full;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tags_q   <= '0;
    end else begin
      if (!bus.tx_active) own_q <= sc_want;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (enq) tags_q[wr_ptr_q] <= tag;
    end
  end
endmodule
